// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - fetch/loader requester ports and memory port bundle for imem_port_arbiter
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 6
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;
    logic              cpu_stall;

    logic              l_req;
    logic              l_we;
    logic              l_lock;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              m_en;
    logic              m_we;
    logic [MEM_AW-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, m_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err, cpu_stall,
        output l_gnt, l_rvalid, l_rdata, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err, cpu_stall,
        input  l_gnt, l_rvalid, l_rdata, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - single-port instruction memory arbiter between CPU fetch and loader/debug port
// Optional CPU anti-starvation limit on loader bursts: define IMEM_ARB_FAIRNESS_EN.
module imem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_AW    = 6,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_port_arbiter_if.slave    bus
);
    localparam logic [0:0] ARB    = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]        state;
    logic              arb_mode;
    logic              force_cpu;
    logic              f_gnt_c;
    logic              l_gnt_c;
    logic              pend_f;
    logic              pend_l;
    logic              err_q;
    logic [DATA_W-1:0] f_hold;
    logic [DATA_W-1:0] l_hold;

    // The cycle l_lock drops is already arbitrated normally, so the CPU can win it.
    assign arb_mode = (state == ARB) || !bus.l_lock;

`ifdef IMEM_ARB_FAIRNESS_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] burst_cnt;

    assign force_cpu = (burst_cnt == CW'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (arb_mode) begin
            if (f_gnt_c || !bus.f_req)
                burst_cnt <= '0;
            else if (l_gnt_c)
                burst_cnt <= burst_cnt + CW'(1);
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    always_comb begin
        f_gnt_c = 1'b0;
        l_gnt_c = 1'b0;
        if (rst_n) begin
            if (arb_mode) begin
                if (bus.l_req && !(force_cpu && bus.f_req))
                    l_gnt_c = 1'b1;
                else if (bus.f_req)
                    f_gnt_c = 1'b1;
            end else begin
                l_gnt_c = bus.l_req;
            end
        end
    end

    assign bus.f_gnt   = f_gnt_c;
    assign bus.l_gnt   = l_gnt_c;
    assign bus.m_en    = f_gnt_c | l_gnt_c;
    assign bus.m_we    = l_gnt_c & bus.l_we;
    assign bus.m_addr  = l_gnt_c ? bus.l_addr[MEM_AW+1:2] :
                         f_gnt_c ? bus.f_addr[MEM_AW+1:2] : '0;
    assign bus.m_wdata = (l_gnt_c && bus.l_we) ? bus.l_wdata : '0;

    // High address bits wrap and loader byte offsets are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.f_addr[ADDR_W-1:MEM_AW+2],
                                bus.l_addr[ADDR_W-1:MEM_AW+2], bus.l_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else if (arb_mode) begin
            state <= (l_gnt_c && bus.l_lock) ? LOCKED : ARB;
        end
    end

    assign bus.cpu_stall = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_f <= 1'b0;
            pend_l <= 1'b0;
            err_q  <= 1'b0;
            f_hold <= '0;
            l_hold <= '0;
        end else begin
            pend_f <= f_gnt_c;
            pend_l <= l_gnt_c & ~bus.l_we;
            err_q  <= f_gnt_c & (bus.f_addr[1:0] != 2'b00);
            if (pend_f)
                f_hold <= bus.m_rdata;
            if (pend_l)
                l_hold <= bus.m_rdata;
        end
    end

    // Memory data is steered straight through in the response cycle, then held.
    assign bus.f_rvalid = pend_f;
    assign bus.f_err    = pend_f & err_q;
    assign bus.f_rdata  = pend_f ? bus.m_rdata : f_hold;
    assign bus.l_rvalid = pend_l;
    assign bus.l_rdata  = pend_l ? bus.m_rdata : l_hold;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MEM_AW(6)) bus ();

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(6), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first synchronous memory; preload applied while reset is sampled low.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[1] <= 32'hDEADBEEF;
            mem[2] <= 32'h00750593;
            bus.m_rdata <= 32'h0;
        end else if (bus.m_en) begin
            if (bus.m_we) begin
                mem[bus.m_addr] <= bus.m_wdata;
                bus.m_rdata     <= bus.m_wdata;
            end else begin
                bus.m_rdata <= mem[bus.m_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cyc();
        @(negedge clk);
    endtask

    initial begin
        logic exp_f;
        rst_n = 1'b0;
        bus.f_req = 1'b1; bus.f_addr = 32'h0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
        bus.l_addr = 32'h0; bus.l_wdata = 32'h0;

        mid_cyc();
        check("rst_f_gnt", bus.f_gnt, 0);
        check("rst_m_en", bus.m_en, 0);
        check("rst_f_rvalid", bus.f_rvalid, 0);
        check("rst_l_rvalid", bus.l_rvalid, 0);
        check("rst_cpu_stall", bus.cpu_stall, 0);
        check("rst_f_rdata", bus.f_rdata, 0);

        // Aligned CPU fetch of word 2
        next_cyc();
        rst_n = 1'b1; bus.f_req = 1'b1; bus.f_addr = 32'h8;
        mid_cyc();
        check("fetch_gnt", bus.f_gnt, 1);
        check("fetch_m_addr", bus.m_addr, 2);
        check("fetch_m_we", bus.m_we, 0);
        next_cyc();
        bus.f_req = 1'b0;
        mid_cyc();
        check("fetch_rvalid", bus.f_rvalid, 1);
        check("fetch_rdata", bus.f_rdata, 32'h00750593);
        check("fetch_err", bus.f_err, 0);
        check("fetch_no_lrvalid", bus.l_rvalid, 0);

        // Loader write then read of word 1
        next_cyc();
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h4; bus.l_wdata = 32'h00B50633;
        mid_cyc();
        check("lwr_gnt", bus.l_gnt, 1);
        check("lwr_m_we", bus.m_we, 1);
        check("lwr_m_addr", bus.m_addr, 1);
        check("lwr_m_wdata", bus.m_wdata, 32'h00B50633);
        next_cyc();
        bus.l_we = 1'b0;
        mid_cyc();
        check("lrd_gnt", bus.l_gnt, 1);
        check("lwr_no_rvalid", bus.l_rvalid, 0);
        next_cyc();
        bus.l_req = 1'b0;
        mid_cyc();
        check("lrd_rvalid", bus.l_rvalid, 1);
        check("lrd_rdata", bus.l_rdata, 32'h00B50633);
        check("lrd_no_frvalid", bus.f_rvalid, 0);
        check("f_rdata_hold", bus.f_rdata, 32'h00750593);

        // Continuous contention
        next_cyc();
        bus.f_req = 1'b1; bus.f_addr = 32'h0;
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cyc();
            mid_cyc();
`ifdef IMEM_ARB_FAIRNESS_EN
            exp_f = ((i % 5) == 4);
`else
            exp_f = 1'b0;
`endif
            check($sformatf("arb_f_gnt_%0d", i), bus.f_gnt, exp_f);
            check($sformatf("arb_l_gnt_%0d", i), bus.l_gnt, !exp_f);
        end
        next_cyc();
        bus.f_req = 1'b0; bus.l_req = 1'b0;

        // Locked download with CPU held off
        next_cyc();
        bus.l_req = 1'b1; bus.l_lock = 1'b1; bus.l_we = 1'b1;
        bus.l_addr = 32'h20; bus.l_wdata = 32'h12345678;
        bus.f_req = 1'b1; bus.f_addr = 32'h0;
        mid_cyc();
        check("lock_l_gnt", bus.l_gnt, 1);
        check("lock_f_gnt", bus.f_gnt, 0);
        check("lock_stall_c0", bus.cpu_stall, 0);
        for (int i = 1; i < 10; i++) begin
            next_cyc();
            bus.l_we = 1'b0;
            mid_cyc();
            check($sformatf("lock_f_gnt_%0d", i), bus.f_gnt, 0);
            check($sformatf("lock_stall_%0d", i), bus.cpu_stall, 1);
            check($sformatf("lock_l_gnt_%0d", i), bus.l_gnt, 1);
            if (i == 2) check("lock_rdata", bus.l_rdata, 32'h12345678);
        end
        next_cyc();
        bus.l_req = 1'b0; bus.l_lock = 1'b0;
        mid_cyc();
        check("unlock_f_gnt", bus.f_gnt, 1);
        check("unlock_stall_hold", bus.cpu_stall, 1);
        check("unlock_l_rvalid", bus.l_rvalid, 1);
        next_cyc();
        bus.f_req = 1'b0;
        mid_cyc();
        check("unlock_stall_fall", bus.cpu_stall, 0);
        check("unlock_f_rvalid", bus.f_rvalid, 1);
        check("unlock_f_rdata", bus.f_rdata, 0);

        // Misaligned fetch
        next_cyc();
        bus.f_req = 1'b1; bus.f_addr = 32'h6;
        mid_cyc();
        check("mis_gnt", bus.f_gnt, 1);
        check("mis_m_addr", bus.m_addr, 1);
        next_cyc();
        bus.f_req = 1'b0;
        mid_cyc();
        check("mis_rvalid", bus.f_rvalid, 1);
        check("mis_rdata", bus.f_rdata, 32'h00B50633);
        check("mis_err", bus.f_err, 1);
        next_cyc();
        mid_cyc();
        check("mis_rvalid_drop", bus.f_rvalid, 0);

        // Reset pulse right after a locked read grant
        next_cyc();
        bus.l_req = 1'b1; bus.l_lock = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h0;
        mid_cyc();
        check("rl_lock_gnt", bus.l_gnt, 1);
        next_cyc();
        mid_cyc();
        check("rl_stall", bus.cpu_stall, 1);
        check("rl_read_gnt", bus.l_gnt, 1);
        next_cyc();
        rst_n = 1'b0;
        bus.l_req = 1'b0; bus.l_lock = 1'b0; bus.f_req = 1'b1; bus.f_addr = 32'h8;
        #1;
        check("rl_in_rst_l_rvalid", bus.l_rvalid, 0);
        check("rl_in_rst_stall", bus.cpu_stall, 0);
        check("rl_in_rst_f_gnt", bus.f_gnt, 0);
        #1;
        rst_n = 1'b1;
        mid_cyc();
        check("rl_post_f_gnt", bus.f_gnt, 1);
        check("rl_post_l_rvalid", bus.l_rvalid, 0);
        check("rl_post_stall", bus.cpu_stall, 0);
        next_cyc();
        bus.f_req = 1'b0;
        mid_cyc();
        check("rl_post_f_rvalid", bus.f_rvalid, 1);
        check("rl_post_f_rdata", bus.f_rdata, 32'h00750593);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
